rx_bridge: RTL and testbench

Receive-side counterpart of the Tx bridge. Accepts TLPs from the Xilinx PCIe core over a 64-bit AXI4-Stream interface. Splits each TLP into a header stream for the header FIFO and a DW-realigned payload stream for the OCP slave side. Prefixed and malformed TLPs are dropped and flagged.

---
 rtl/rx_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_rx_bridge.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bridge.sv
// Receive bridge: splits PCIe Rx TLPs arriving on a 64-bit AXI4-Stream into a header stream
// and a DW-realigned payload stream. It drops prefixed TLPs and flags length mismatches.
module rx_bridge #(
    parameter int unsigned FIFO_WDTH = 64,
    parameter int unsigned DATA_WDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 AXI_in_valid,
    output logic                 AXI_in_ready,
    input  logic [FIFO_WDTH-1:0] AXI_in_data,
    input  logic [DATA_WDTH-1:0] AXI_in_keep,
    input  logic                 AXI_in_last,
    output logic                 header_valid,
    input  logic                 header_ready,
    output logic [FIFO_WDTH-1:0] header_data,
    output logic [DATA_WDTH-1:0] header_keep,
    output logic                 header_last,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic [FIFO_WDTH-1:0] data_data,
    output logic [DATA_WDTH-1:0] data_keep,
    output logic                 data_last,
    output logic                 rx_error
);

    localparam logic [DATA_WDTH-1:0] KeepFull = DATA_WDTH'(8'hFF);
    localparam logic [DATA_WDTH-1:0] KeepLow  = DATA_WDTH'(8'h0F);

    typedef enum logic [2:0] {StIdle, StHdr1, StData, StFlush, StDrop} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_hdr_valid, r_hdr_last, r_dat_valid, r_dat_last, r_err;
    logic [FIFO_WDTH-1:0]   r_hdr_data, r_dat_data;
    logic [DATA_WDTH-1:0]   r_hdr_keep, r_dat_keep;
    logic [31:0]            r_hold, w_hold_nxt;
    logic [10:0]            r_rem, w_rem_nxt, r_len, w_len_nxt;
    logic                   r_is4, w_is4_nxt, r_pay, w_pay_nxt, r_drop_after, w_drop_after_nxt;

    logic                   w_ready, w_fire, w_dat_free, w_err_nxt;
    logic                   w_hdr_load, w_hdr_last_nxt, w_dat_load, w_dat_last_nxt;
    logic [FIFO_WDTH-1:0]   w_hdr_data_nxt, w_dat_data_nxt;
    logic [DATA_WDTH-1:0]   w_hdr_keep_nxt, w_dat_keep_nxt;
    logic [10:0]            w_len_in, w_rem_sub;
    logic                   w_unused_keep;

    // Byte enables are not needed: the length field alone governs payload extent.
    assign w_unused_keep = ^AXI_in_keep;

    assign w_fire     = AXI_in_valid & w_ready;
    assign w_dat_free = !r_dat_valid | data_ready;
    assign w_len_in   = (AXI_in_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, AXI_in_data[9:0]};
    assign w_rem_sub  = (r_rem >= 11'd2) ? (r_rem - 11'd2) : 11'd0;

    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            StIdle, StHdr1: w_ready = !r_hdr_valid | header_ready;
            StData:         w_ready = w_dat_free;
            StDrop:         w_ready = 1'b1;
            default:        w_ready = 1'b0;
        endcase
        if (reset) begin
            w_ready = 1'b0;
        end
    end

    assign AXI_in_ready = w_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_hdr_load       = 1'b0;
        w_hdr_data_nxt   = AXI_in_data;
        w_hdr_keep_nxt   = KeepFull;
        w_hdr_last_nxt   = 1'b0;
        w_dat_load       = 1'b0;
        w_dat_data_nxt   = AXI_in_data;
        w_dat_keep_nxt   = KeepFull;
        w_dat_last_nxt   = 1'b0;
        w_err_nxt        = 1'b0;
        w_hold_nxt       = r_hold;
        w_rem_nxt        = r_rem;
        w_len_nxt        = r_len;
        w_is4_nxt        = r_is4;
        w_pay_nxt        = r_pay;
        w_drop_after_nxt = r_drop_after;

        unique case (r_state)
            StIdle: begin
                if (w_fire) begin
                    if (AXI_in_last) begin
                        w_err_nxt = 1'b1;
                    end else if (AXI_in_data[31]) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = StDrop;
                    end else begin
                        w_hdr_load  = 1'b1;
                        w_len_nxt   = w_len_in;
                        w_is4_nxt   = AXI_in_data[29];
                        w_pay_nxt   = AXI_in_data[30];
                        w_state_nxt = StHdr1;
                    end
                end
            end
            StHdr1: begin
                if (w_fire) begin
                    w_hdr_load     = 1'b1;
                    w_hdr_last_nxt = 1'b1;
                    if (!r_is4) begin
                        w_hdr_data_nxt = {32'b0, AXI_in_data[31:0]};
                        w_hdr_keep_nxt = KeepLow;
                    end
                    if (!r_pay) begin
                        w_err_nxt   = !AXI_in_last;
                        w_state_nxt = AXI_in_last ? StIdle : StDrop;
                    end else if (r_is4) begin
                        w_rem_nxt   = r_len;
                        w_err_nxt   = AXI_in_last;
                        w_state_nxt = AXI_in_last ? StIdle : StData;
                    end else begin
                        // 3DW: payload DW0 rides in the upper half of the second header beat.
                        w_hold_nxt = AXI_in_data[63:32];
                        w_rem_nxt  = r_len - 11'd1;
                        if (r_len == 11'd1) begin
                            w_drop_after_nxt = !AXI_in_last;
                            w_err_nxt        = !AXI_in_last;
                            w_state_nxt      = StFlush;
                        end else if (AXI_in_last) begin
                            w_drop_after_nxt = 1'b0;
                            w_err_nxt        = 1'b1;
                            w_state_nxt      = StFlush;
                        end else begin
                            w_state_nxt = StData;
                        end
                    end
                end
            end
            StData: begin
                if (w_fire) begin
                    w_dat_load = 1'b1;
                    w_rem_nxt  = w_rem_sub;
                    if (r_is4) begin
                        w_dat_keep_nxt = (r_rem >= 11'd2) ? KeepFull : KeepLow;
                        if (r_rem <= 11'd2) begin
                            w_dat_last_nxt = 1'b1;
                            w_err_nxt      = !AXI_in_last;
                            w_state_nxt    = AXI_in_last ? StIdle : StDrop;
                        end else if (AXI_in_last) begin
                            w_dat_last_nxt = 1'b1;
                            w_err_nxt      = 1'b1;
                            w_state_nxt    = StIdle;
                        end
                    end else begin
                        w_dat_data_nxt = {AXI_in_data[31:0], r_hold};
                        w_hold_nxt     = AXI_in_data[63:32];
                        if (r_rem == 11'd1) begin
                            w_dat_last_nxt = 1'b1;
                            w_err_nxt      = !AXI_in_last;
                            w_state_nxt    = AXI_in_last ? StIdle : StDrop;
                        end else if (r_rem == 11'd2) begin
                            // Upper input DW is the final payload DW; it leaves via FLUSH.
                            w_drop_after_nxt = !AXI_in_last;
                            w_err_nxt        = !AXI_in_last;
                            w_state_nxt      = StFlush;
                        end else if (AXI_in_last) begin
                            w_dat_last_nxt = 1'b1;
                            w_err_nxt      = 1'b1;
                            w_state_nxt    = StIdle;
                        end
                    end
                end
            end
            StFlush: begin
                if (w_dat_free) begin
                    w_dat_load     = 1'b1;
                    w_dat_data_nxt = {32'b0, r_hold};
                    w_dat_keep_nxt = KeepLow;
                    w_dat_last_nxt = 1'b1;
                    w_state_nxt    = r_drop_after ? StDrop : StIdle;
                end
            end
            StDrop: begin
                if (w_fire && AXI_in_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_hdr_valid  <= 1'b0;
            r_hdr_data   <= '0;
            r_hdr_keep   <= '0;
            r_hdr_last   <= 1'b0;
            r_dat_valid  <= 1'b0;
            r_dat_data   <= '0;
            r_dat_keep   <= '0;
            r_dat_last   <= 1'b0;
            r_err        <= 1'b0;
            r_hold       <= '0;
            r_rem        <= '0;
            r_len        <= '0;
            r_is4        <= 1'b0;
            r_pay        <= 1'b0;
            r_drop_after <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_err        <= w_err_nxt;
            r_hold       <= w_hold_nxt;
            r_rem        <= w_rem_nxt;
            r_len        <= w_len_nxt;
            r_is4        <= w_is4_nxt;
            r_pay        <= w_pay_nxt;
            r_drop_after <= w_drop_after_nxt;
            if (w_hdr_load) begin
                r_hdr_valid <= 1'b1;
                r_hdr_data  <= w_hdr_data_nxt;
                r_hdr_keep  <= w_hdr_keep_nxt;
                r_hdr_last  <= w_hdr_last_nxt;
            end else if (header_ready) begin
                r_hdr_valid <= 1'b0;
            end
            if (w_dat_load) begin
                r_dat_valid <= 1'b1;
                r_dat_data  <= w_dat_data_nxt;
                r_dat_keep  <= w_dat_keep_nxt;
                r_dat_last  <= w_dat_last_nxt;
            end else if (data_ready) begin
                r_dat_valid <= 1'b0;
            end
        end
    end

    assign header_valid = r_hdr_valid;
    assign header_data  = r_hdr_data;
    assign header_keep  = r_hdr_keep;
    assign header_last  = r_hdr_last;
    assign data_valid   = r_dat_valid;
    assign data_data    = r_dat_data;
    assign data_keep    = r_dat_keep;
    assign data_last    = r_dat_last;
    assign rx_error     = r_err;

endmodule

// File: tb/tb_rx_bridge.sv
// Self-checking bench for rx_bridge: random TLP contents and stalls checked against a
// stream-level model of header/payload splitting.
module tb_rx_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        AXI_in_valid = 1'b0;
    logic        AXI_in_ready;
    logic [63:0] AXI_in_data = '0;
    logic [7:0]  AXI_in_keep = '0;
    logic        AXI_in_last = 1'b0;
    logic        header_valid, header_last, data_valid, data_last, rx_error;
    logic        header_ready = 1'b1;
    logic        data_ready = 1'b1;
    logic [63:0] header_data, data_data;
    logic [7:0]  header_keep, data_keep;

    rx_bridge #(.FIFO_WDTH(64), .DATA_WDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .AXI_in_valid (AXI_in_valid),
        .AXI_in_ready (AXI_in_ready),
        .AXI_in_data  (AXI_in_data),
        .AXI_in_keep  (AXI_in_keep),
        .AXI_in_last  (AXI_in_last),
        .header_valid (header_valid),
        .header_ready (header_ready),
        .header_data  (header_data),
        .header_keep  (header_keep),
        .header_last  (header_last),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_data    (data_data),
        .data_keep    (data_keep),
        .data_last    (data_last),
        .rx_error     (rx_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_hdr[$], exp_dat[$], got_hdr[$], got_dat[$];
    logic [31:0] dw_q[$];
    int unsigned got_err, exp_err;
    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          stall_en = 1'b0;
    bit          bubble_en = 1'b0;

    always @(posedge clk) begin
        #1;
        header_ready = stall_en ? ($urandom_range(1) == 1) : 1'b1;
        data_ready   = stall_en ? ($urandom_range(1) == 1) : 1'b1;
    end

    // Output monitor: captures handshakes, counts error pulses, checks stability under stall.
    beat_t cur_h, cur_d, p_h, p_d;
    bit    p_hstall = 1'b0;
    bit    p_dstall = 1'b0;
    always @(negedge clk) begin
        cur_h = {header_data, header_keep, header_last};
        cur_d = {data_data, data_keep, data_last};
        if (reset) begin
            p_hstall = 1'b0;
            p_dstall = 1'b0;
        end else begin
            if (p_hstall) begin
                checks++;
                assert ((header_valid === 1'b1) && (cur_h === p_h)) else begin
                    errors++;
                    $error("FAIL hdr_stable got=%b/%h want=1/%h", header_valid, cur_h, p_h);
                end
            end
            if (p_dstall) begin
                checks++;
                assert ((data_valid === 1'b1) && (cur_d === p_d)) else begin
                    errors++;
                    $error("FAIL dat_stable got=%b/%h want=1/%h", data_valid, cur_d, p_d);
                end
            end
            if (header_valid && header_ready) got_hdr.push_back(cur_h);
            if (data_valid && data_ready) got_dat.push_back(cur_d);
            if (rx_error === 1'b1) got_err++;
            p_hstall = header_valid && !header_ready;
            p_dstall = data_valid && !data_ready;
            p_h = cur_h;
            p_d = cur_d;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic gen_tlp(input logic [2:0] fmt, input int len);
        int total;
        dw_q.delete();
        total = (fmt[0] ? 4 : 3) + (fmt[1] ? len : 0);
        dw_q.push_back({fmt, 5'($urandom), 14'($urandom), 10'(len)});
        for (int i = 1; i < total; i++) dw_q.push_back($urandom);
        if (total % 2 == 1) dw_q.push_back($urandom);
    endtask

    // Reference: header DWs go to the header stream, payload DWs are packed two per beat from
    // DW0 upward; a lone final DW has keep 0F (4DW passes the raw pad DW above it).
    task automatic model();
        logic [31:0] d0;
        int          len, hl;
        bit          is4, pay;
        beat_t       b;
        d0  = dw_q[0];
        is4 = d0[29];
        pay = d0[30];
        hl  = is4 ? 4 : 3;
        len = (d0[9:0] == 10'd0) ? 1024 : int'(d0[9:0]);
        b.data = {dw_q[1], dw_q[0]};
        b.keep = 8'hFF;
        b.last = 1'b0;
        exp_hdr.push_back(b);
        b.data = is4 ? {dw_q[3], dw_q[2]} : {32'h0, dw_q[2]};
        b.keep = is4 ? 8'hFF : 8'h0F;
        b.last = 1'b1;
        exp_hdr.push_back(b);
        if (pay) begin
            for (int i = 0; i < len; i += 2) begin
                if (i + 1 < len) begin
                    b.data = {dw_q[hl+i+1], dw_q[hl+i]};
                    b.keep = 8'hFF;
                end else begin
                    b.data = {(is4 ? dw_q[hl+i+1] : 32'h0), dw_q[hl+i]};
                    b.keep = 8'h0F;
                end
                b.last = (i + 2 >= len);
                exp_dat.push_back(b);
            end
        end
    endtask

    task automatic wait_accept();
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = AXI_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (acc === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout got=%b want=1", acc);
        end
    endtask

    task automatic send_beats(input int stop, input bit mark_last);
        for (int b = 0; b <= stop; b++) begin
            if (bubble_en && $urandom_range(3) == 0) begin
                AXI_in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            AXI_in_valid = 1'b1;
            AXI_in_data  = {dw_q[2*b+1], dw_q[2*b]};
            AXI_in_keep  = 8'($urandom);
            AXI_in_last  = mark_last && (b == stop);
            wait_accept();
        end
        AXI_in_valid = 1'b0;
        AXI_in_last  = 1'b0;
    endtask

    task automatic drain();
        int idle, n;
        idle = 0;
        n = 0;
        while (idle < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!header_valid && !data_valid) idle++;
            else idle = 0;
        end
        checks++;
        assert (idle >= 4) else begin
            errors++;
            $error("FAIL drain_timeout got=%0d want=4", idle);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        int n;
        checks++;
        assert (got_hdr.size() === exp_hdr.size()) else begin
            errors++;
            $error("FAIL %s hdr_count got=%0d want=%0d", tag, got_hdr.size(), exp_hdr.size());
        end
        n = (got_hdr.size() < exp_hdr.size()) ? got_hdr.size() : exp_hdr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (got_hdr[i] === exp_hdr[i]) else begin
                errors++;
                $error("FAIL %s hdr[%0d] got=%h want=%h", tag, i, got_hdr[i], exp_hdr[i]);
            end
        end
        checks++;
        assert (got_dat.size() === exp_dat.size()) else begin
            errors++;
            $error("FAIL %s dat_count got=%0d want=%0d", tag, got_dat.size(), exp_dat.size());
        end
        n = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (got_dat[i] === exp_dat[i]) else begin
                errors++;
                $error("FAIL %s dat[%0d] got=%h want=%h", tag, i, got_dat[i], exp_dat[i]);
            end
        end
        checks++;
        assert (got_err === exp_err) else begin
            errors++;
            $error("FAIL %s rx_error got=%0d want=%0d", tag, got_err, exp_err);
        end
        got_hdr.delete();
        got_dat.delete();
        exp_hdr.delete();
        exp_dat.delete();
        got_err = 0;
        exp_err = 0;
    endtask

    task automatic run_tlp(input string tag);
        model();
        send_beats(dw_q.size() / 2 - 1, 1'b1);
        drain();
        compare(tag);
    endtask

    task automatic check_zero(input string tag);
        logic [151:0] got;
        got = {header_valid, data_valid, rx_error, AXI_in_ready, header_data, header_keep,
               header_last, data_data, data_keep, data_last, 2'b00};
        checks++;
        assert (got === 152'h0) else begin
            errors++;
            $error("FAIL %s got=%h want=0", tag, got);
        end
    endtask

    initial begin
        got_err = 0;
        exp_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        #1;
        checks++;
        assert (AXI_in_ready === 1'b1) else begin
            errors++;
            $error("FAIL idle_ready got=%b want=1", AXI_in_ready);
        end
        @(posedge clk);
        #1;

        gen_tlp(3'b000, 1);
        run_tlp("mrd3_len1");
        gen_tlp(3'b011, 4);
        run_tlp("mwr4_len4");
        gen_tlp(3'b010, 3);
        run_tlp("mwr3_len3");
        gen_tlp(3'b010, 2);
        run_tlp("mwr3_len2");
        gen_tlp(3'b010, 1);
        run_tlp("mwr3_len1");
        gen_tlp(3'b010, 1024);
        run_tlp("mwr3_len1024");
        gen_tlp(3'b011, 5);
        run_tlp("mwr4_len5");

        gen_tlp(3'b011, 8);
        run_tlp("mwr4_len8_nostall");
        stall_en = 1'b1;
        run_tlp("mwr4_len8_stall");
        stall_en = 1'b0;

        gen_tlp(3'b100, 2);
        dw_q.push_back($urandom);
        dw_q.push_back($urandom);
        exp_err = 1;
        send_beats(2, 1'b1);
        drain();
        compare("prefix_drop");

        gen_tlp(3'b010, 4);
        exp_err = 1;
        send_beats(0, 1'b1);
        drain();
        compare("beat0_last");

        gen_tlp(3'b011, 4);
        model();
        exp_dat.delete();
        exp_dat.push_back({dw_q[5], dw_q[4], 8'hFF, 1'b1});
        exp_err = 1;
        send_beats(2, 1'b1);
        drain();
        compare("early_last");

        gen_tlp(3'b011, 3);
        model();
        exp_err = 1;
        send_beats(dw_q.size() / 2 - 1, 1'b0);
        dw_q.delete();
        dw_q.push_back($urandom);
        dw_q.push_back($urandom);
        send_beats(0, 1'b1);
        drain();
        compare("missing_last");

        gen_tlp(3'b000, 1);
        model();
        exp_err = 1;
        dw_q.push_back($urandom);
        dw_q.push_back($urandom);
        send_beats(2, 1'b1);
        drain();
        compare("nopay_extra");

        gen_tlp(3'b011, 8);
        send_beats(2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("reset_in_data");
        reset = 1'b0;
        got_hdr.delete();
        got_dat.delete();
        got_err = 0;
        gen_tlp(3'b010, 5);
        run_tlp("after_reset");

        for (int t = 0; t < 25; t++) begin
            stall_en  = ($urandom_range(1) == 1);
            bubble_en = ($urandom_range(1) == 1);
            gen_tlp(3'($urandom_range(3)), $urandom_range(24, 1));
            run_tlp("random");
        end
        stall_en  = 1'b0;
        bubble_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
